uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares one `uart` transmit FIFO among `NUM_REQ` byte-stream requesters. Grants are held for a whole packet, so one requester's bytes are never interleaved with another's. A packet ends on `req_last` or after `MAX_BURST` bytes. The block sits between producer blocks and the `uart` TX write port (`uart_tx_start` / `uart_tx_data_in` / `uart_tx_fifo_full`). It can optionally prefix each burst with a source tag byte.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 143 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the byte-stream requesters, the arbiter and the uart TX write port.
// Signal prefixes follow the arbiter's point of view: i_ into the arbiter, o_ out of it.
interface uart_tx_arbiter_if #(
   parameter int unsigned NUM_REQ = 4
) ();
   logic [NUM_REQ-1:0]   i_req;
   logic [8*NUM_REQ-1:0] i_req_data;
   logic [NUM_REQ-1:0]   i_req_last;
   logic                 i_uart_tx_fifo_full;
   logic [NUM_REQ-1:0]   o_ack;
   logic [NUM_REQ-1:0]   o_grant;
   logic                 o_busy;
   logic                 o_uart_tx_start;
   logic [7:0]           o_uart_tx_data_in;

   modport master (
      output i_req, i_req_data, i_req_last, i_uart_tx_fifo_full,
      input  o_ack, o_grant, o_busy, o_uart_tx_start, o_uart_tx_data_in
   );

   modport slave (
      input  i_req, i_req_data, i_req_last, i_uart_tx_fifo_full,
      output o_ack, o_grant, o_busy, o_uart_tx_start, o_uart_tx_data_in
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart TX FIFO among NUM_REQ byte streams.
// A grant is held for a whole packet (req_last or MAX_BURST bytes), optionally prefixed by a tag byte.
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned MAX_BURST  = 16,
   parameter bit          TAG_ENABLE = 1'b0,
   parameter logic [7:0]  TAG_BASE   = 8'hA0
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_arbiter_if.slave bus
);
   localparam int unsigned IW = $clog2(NUM_REQ);
   localparam int unsigned CW = $clog2(MAX_BURST + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TAG  = 2'd1,
      ST_SEND = 2'd2
   } state_t;

   state_t             r_state;
   logic [IW-1:0]      r_cur;
   logic [IW-1:0]      r_last;
   logic [CW-1:0]      r_cnt;
   logic [NUM_REQ-1:0] r_grant;
   logic               r_busy;

   logic [IW-1:0]      w_sel;
   logic [IW:0]        w_idx;
   logic               w_req_cur;
   logic               w_last_cur;
   logic [7:0]         w_byte_cur;
   logic [CW:0]        w_cnt_inc;
   logic               w_burst_end;
   logic               w_start;
   logic [7:0]         w_data;
   logic [NUM_REQ-1:0] w_ack;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] idx);
      onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   // Round-robin pick: scan downwards so the nearest requester after r_last wins.
   always_comb begin
      w_sel = r_last;
      w_idx = {(IW+1){1'b0}};
      for (int k = NUM_REQ; k >= 1; k--) begin
         w_idx = {1'b0, r_last} + (IW+1)'(k);
         w_idx = (w_idx >= (IW+1)'(NUM_REQ)) ? (w_idx - (IW+1)'(NUM_REQ)) : w_idx;
         w_sel = bus.i_req[w_idx[IW-1:0]] ? w_idx[IW-1:0] : w_sel;
      end
   end

   assign w_req_cur   = bus.i_req[r_cur];
   assign w_last_cur  = bus.i_req_last[r_cur];
   assign w_byte_cur  = bus.i_req_data[{r_cur, 3'b000} +: 8];
   assign w_cnt_inc   = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
   assign w_burst_end = w_last_cur || (w_cnt_inc == (CW+1)'(MAX_BURST));

   // Write strobe, data and ack are combinational so a byte moves in the cycle it is offered.
   always_comb begin
      w_start = 1'b0;
      w_data  = 8'h00;
      w_ack   = {NUM_REQ{1'b0}};
      case (r_state)
         ST_TAG: begin
            w_start = !bus.i_uart_tx_fifo_full;
            w_data  = TAG_BASE + {{(8-IW){1'b0}}, r_cur};
         end
         ST_SEND: begin
            w_start = w_req_cur && !bus.i_uart_tx_fifo_full;
            w_data  = w_byte_cur;
            w_ack   = w_start ? onehot(r_cur) : {NUM_REQ{1'b0}};
         end
         default: begin
            w_start = 1'b0;
            w_data  = 8'h00;
            w_ack   = {NUM_REQ{1'b0}};
         end
      endcase
   end

   // Arbitration FSM with registered grant/busy.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cur   <= {IW{1'b0}};
         r_last  <= IW'(NUM_REQ - 1);
         r_cnt   <= {CW{1'b0}};
         r_grant <= {NUM_REQ{1'b0}};
         r_busy  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (|bus.i_req) begin
                  r_cur   <= w_sel;
                  r_grant <= onehot(w_sel);
                  r_cnt   <= {CW{1'b0}};
                  r_busy  <= 1'b1;
                  r_state <= TAG_ENABLE ? ST_TAG : ST_SEND;
               end else begin
                  r_grant <= {NUM_REQ{1'b0}};
                  r_busy  <= 1'b0;
               end
            end
            ST_TAG: begin
               if (!bus.i_uart_tx_fifo_full) begin
                  r_state <= ST_SEND;
               end
            end
            ST_SEND: begin
               // A dropped req abandons the packet; full with req held is a pure stall.
               if (!w_req_cur) begin
                  r_state <= ST_IDLE;
                  r_last  <= r_cur;
                  r_grant <= {NUM_REQ{1'b0}};
                  r_busy  <= 1'b0;
               end else if (!bus.i_uart_tx_fifo_full) begin
                  r_cnt <= w_cnt_inc[CW-1:0];
                  if (w_burst_end) begin
                     r_state <= ST_IDLE;
                     r_last  <= r_cur;
                     r_grant <= {NUM_REQ{1'b0}};
                     r_busy  <= 1'b0;
                  end
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_grant <= {NUM_REQ{1'b0}};
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_ack             = w_ack;
   assign bus.o_grant           = r_grant;
   assign bus.o_busy            = r_busy;
   assign bus.o_uart_tx_start   = w_start;
   assign bus.o_uart_tx_data_in = w_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: two instances (MAX_BURST=4 untagged, MAX_BURST=16 tagged) fed from
// per-requester byte queues and scored against a packet-level round-robin model.
module tb_uart_tx_arbiter;
   localparam int N = 4;

   typedef struct packed {
      logic [7:0]   b;
      logic         tg;
      logic [N-1:0] oh;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   uart_tx_arbiter_if #(.NUM_REQ(N)) ifa ();
   uart_tx_arbiter_if #(.NUM_REQ(N)) ifb ();

   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(4), .TAG_ENABLE(1'b0), .TAG_BASE(8'hA0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(ifa.slave)
   );
   uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(16), .TAG_ENABLE(1'b1), .TAG_BASE(8'hA0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(ifb.slave)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [8:0]   qa [N][$];
   logic [8:0]   qb [N][$];
   exp_t         ea [$];
   exp_t         eb [$];
   logic [N-1:0] served_a [$];
   logic         full_a = 1'b0;
   logic         full_b = 1'b0;
   bit           sb_on  = 1'b1;

   logic         a_start, b_start, a_busy, b_busy;
   logic [7:0]   a_data, b_data;
   logic [N-1:0] a_ack, b_ack, a_grant, b_grant;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Packet-level model: whoever still holds bytes when the arbiter is idle is requesting.
   task automatic build_model(input bit is_b);
      logic [8:0] m [N][$];
      exp_t       e;
      logic [8:0] it;
      int         owner, last, n, mx, idx;
      bit         done;
      for (int i = 0; i < N; i++) begin
         if (is_b) m[i] = qb[i];
         else      m[i] = qa[i];
      end
      mx   = is_b ? 16 : 4;
      last = N - 1;
      forever begin
         owner = -1;
         for (int k = 1; k <= N; k++) begin
            idx = (last + k) % N;
            if (m[idx].size() != 0) begin
               owner = idx;
               break;
            end
         end
         if (owner < 0) break;
         if (is_b) begin
            e.b  = 8'hA0 + 8'(owner);
            e.tg = 1'b1;
            e.oh = N'(1) << owner;
            eb.push_back(e);
         end
         n    = 0;
         done = 1'b0;
         while (!done) begin
            it   = m[owner].pop_front();
            n++;
            e.b  = it[7:0];
            e.tg = 1'b0;
            e.oh = N'(1) << owner;
            if (is_b) eb.push_back(e);
            else      ea.push_back(e);
            done = it[8] || (n >= mx) || (m[owner].size() == 0);
         end
         last = owner;
      end
   endtask

   task automatic arm();
      ea.delete();
      eb.delete();
      build_model(1'b0);
      build_model(1'b1);
   endtask

   task automatic score(input bit is_b, input logic start, input logic [7:0] data,
                        input logic [N-1:0] ack, input logic [N-1:0] grant);
      exp_t  e;
      string p;
      bit    empty;
      p     = is_b ? "b" : "a";
      empty = is_b ? (eb.size() == 0) : (ea.size() == 0);
      if (!start) begin
         check_eq({p, "_idle_ack"}, ack, 0);
      end else if (empty) begin
         check_eq({p, "_extra_write"}, 1, 0);
      end else begin
         if (is_b) e = eb.pop_front();
         else      e = ea.pop_front();
         check_eq({p, "_data"}, data, e.b);
         check_eq({p, "_ack"}, ack, e.tg ? 0 : e.oh);
         check_eq({p, "_grant"}, grant, e.oh);
      end
   endtask

   task automatic drive();
      logic [N-1:0]   r, l;
      logic [8*N-1:0] d;
      for (int i = 0; i < N; i++) begin
         r[i]         = qa[i].size() != 0;
         d[8*i +: 8]  = r[i] ? qa[i][0][7:0] : 8'h00;
         l[i]         = r[i] ? qa[i][0][8] : 1'b0;
      end
      ifa.i_req = r; ifa.i_req_data = d; ifa.i_req_last = l; ifa.i_uart_tx_fifo_full = full_a;
      for (int i = 0; i < N; i++) begin
         r[i]         = qb[i].size() != 0;
         d[8*i +: 8]  = r[i] ? qb[i][0][7:0] : 8'h00;
         l[i]         = r[i] ? qb[i][0][8] : 1'b0;
      end
      ifb.i_req = r; ifb.i_req_data = d; ifb.i_req_last = l; ifb.i_uart_tx_fifo_full = full_b;
   endtask

   // One clock: present inputs on the falling edge, sample just after, retire acked bytes.
   task automatic cycle();
      @(negedge clk);
      drive();
      #1;
      a_start = ifa.o_uart_tx_start; a_data = ifa.o_uart_tx_data_in; a_ack = ifa.o_ack;
      a_grant = ifa.o_grant;         a_busy = ifa.o_busy;
      b_start = ifb.o_uart_tx_start; b_data = ifb.o_uart_tx_data_in; b_ack = ifb.o_ack;
      b_grant = ifb.o_grant;         b_busy = ifb.o_busy;
      check_eq("a_write_while_full", a_start & full_a, 0);
      check_eq("b_write_while_full", b_start & full_b, 0);
      check_eq("a_busy_vs_grant", a_busy, a_grant != 0);
      check_eq("b_busy_vs_grant", b_busy, b_grant != 0);
      if (sb_on) begin
         score(1'b0, a_start, a_data, a_ack, a_grant);
         score(1'b1, b_start, b_data, b_ack, b_grant);
      end
      if (a_start) served_a.push_back(a_ack);
      for (int i = 0; i < N; i++) begin
         if (a_ack[i] && qa[i].size() != 0) void'(qa[i].pop_front());
         if (b_ack[i] && qb[i].size() != 0) void'(qb[i].pop_front());
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      for (int i = 0; i < N; i++) begin
         qa[i].delete();
         qb[i].delete();
      end
      full_a = 1'b0;
      full_b = 1'b0;
      drive();
      @(negedge clk);
      rst_n = 1'b1;
      ea.delete();
      eb.delete();
      served_a.delete();
      sb_on = 1'b1;
   endtask

   task automatic run_until_drained(input int budget, input bit rnd_full);
      int c = 0;
      while ((ea.size() != 0 || eb.size() != 0) && c < budget) begin
         if (rnd_full) begin
            full_a = ($urandom_range(0, 3) == 0);
            full_b = ($urandom_range(0, 3) == 0);
         end
         cycle();
         c++;
      end
      full_a = 1'b0;
      full_b = 1'b0;
      check_eq("a_drained", ea.size(), 0);
      check_eq("b_drained", eb.size(), 0);
      repeat (3) cycle();
   endtask

   initial begin
      // Reset values
      do_reset();
      cycle();
      check_eq("rst_grant", a_grant, 0);
      check_eq("rst_busy", a_busy, 0);
      check_eq("rst_start", a_start, 0);
      check_eq("rst_ack", a_ack, 0);
      check_eq("rst_data", a_data, 0);
      check_eq("rst_b_grant", b_grant, 0);

      // Requester 1 alone, 3 bytes
      do_reset();
      qa[1].push_back(9'h011); qa[1].push_back(9'h022); qa[1].push_back(9'h133);
      arm();
      cycle();
      check_eq("t1_c0_grant", a_grant, 0);
      for (int c = 1; c <= 3; c++) begin
         cycle();
         check_eq("t1_grant", a_grant, 4'b0010);
         check_eq("t1_start", a_start, 1);
         check_eq("t1_byte", a_data, 8'(17 * c));
         check_eq("t1_ack", a_ack, 4'b0010);
      end
      cycle();
      check_eq("t1_idle_busy", a_busy, 0);
      check_eq("t1_idle_grant", a_grant, 0);

      // Requesters 0 and 2 together, 0 re-requests: order 0,2,0
      do_reset();
      qa[0].push_back(9'h1AA); qa[0].push_back(9'h1BB); qa[2].push_back(9'h1CC);
      arm();
      run_until_drained(50, 1'b0);
      check_eq("t2_count", served_a.size(), 3);
      if (served_a.size() == 3) begin
         check_eq("t2_first", served_a[0], 4'b0001);
         check_eq("t2_second", served_a[1], 4'b0100);
         check_eq("t2_third", served_a[2], 4'b0001);
      end

      // MAX_BURST=4 split of a 6-byte packet without last
      do_reset();
      for (int j = 0; j < 6; j++) qa[3].push_back({1'b0, 8'(8'h30 + j)});
      arm();
      cycle();
      for (int c = 1; c <= 4; c++) begin
         cycle();
         check_eq("t3_byte", a_data, 8'(8'h30 + c - 1));
         check_eq("t3_grant", a_grant, 4'b1000);
      end
      cycle();
      check_eq("t3_gap_busy", a_busy, 0);
      check_eq("t3_gap_start", a_start, 0);
      cycle();
      check_eq("t3_regrant", a_grant, 4'b1000);
      check_eq("t3_byte5", a_data, 8'h34);
      cycle();
      check_eq("t3_byte6", a_data, 8'h35);
      cycle();
      check_eq("t3_abandon_start", a_start, 0);
      check_eq("t3_abandon_busy", a_busy, 1);
      cycle();
      check_eq("t3_after_busy", a_busy, 0);

      // FIFO full for 5 cycles mid-packet
      do_reset();
      for (int j = 0; j < 5; j++) qa[1].push_back({(j == 4) ? 1'b1 : 1'b0, 8'(8'h40 + j)});
      arm();
      repeat (3) cycle();
      full_a = 1'b1;
      repeat (5) begin
         cycle();
         check_eq("t4_stall_start", a_start, 0);
         check_eq("t4_stall_ack", a_ack, 0);
         check_eq("t4_stall_grant", a_grant, 4'b0010);
      end
      full_a = 1'b0;
      cycle();
      check_eq("t4_resume_start", a_start, 1);
      check_eq("t4_resume_byte", a_data, 8'h42);
      run_until_drained(50, 1'b0);

      // Tag byte ahead of the burst
      do_reset();
      qb[2].push_back(9'h155);
      arm();
      cycle();
      cycle();
      check_eq("t5_tag_start", b_start, 1);
      check_eq("t5_tag_byte", b_data, 8'hA2);
      check_eq("t5_tag_ack", b_ack, 0);
      check_eq("t5_tag_grant", b_grant, 4'b0100);
      cycle();
      check_eq("t5_data_byte", b_data, 8'h55);
      check_eq("t5_data_ack", b_ack, 4'b0100);
      cycle();
      check_eq("t5_idle_busy", b_busy, 0);

      // One-cycle reset mid-burst, then 0 beats 1
      do_reset();
      sb_on = 1'b0;
      for (int j = 0; j < 4; j++) qa[1].push_back({(j == 3) ? 1'b1 : 1'b0, 8'(8'h50 + j)});
      repeat (3) cycle();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      qa[0].push_back(9'h166);
      cycle();
      check_eq("t6_rst_grant", a_grant, 0);
      check_eq("t6_rst_busy", a_busy, 0);
      check_eq("t6_rst_start", a_start, 0);
      check_eq("t6_rst_ack", a_ack, 0);
      check_eq("t6_rst_data", a_data, 0);
      cycle();
      check_eq("t6_grant0", a_grant, 4'b0001);
      check_eq("t6_byte", a_data, 8'h66);

      // Randomized packets with random FIFO back-pressure
      for (int r = 0; r < 8; r++) begin
         do_reset();
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) != 0) begin
               for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
                  int len = int'($urandom_range(1, 7));
                  for (int j = 0; j < len; j++) qa[i].push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
               end
            end
            if ($urandom_range(0, 3) != 0) begin
               for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
                  int len = int'($urandom_range(1, 7));
                  for (int j = 0; j < len; j++) qb[i].push_back({(j == len - 1) ? 1'b1 : 1'b0, 8'($urandom)});
               end
            end
         end
         arm();
         run_until_drained(1000, 1'b1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
